// File: rtl/hash_digest_reader_pkg.sv
// Purpose: shared types and constants for the hash digest reader slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, word index type, DIGEST_WORDS, word_at() helper.
package hash_digest_reader_pkg;

    localparam int DIGEST_WORDS = 8;
    localparam int IDX_W        = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(DIGEST_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Select H[idx] from a {H0..H7} digest; H0 sits in the top 32 bits.
    function automatic logic [31:0] word_at(input logic [255:0] d, input idx_t idx);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < DIGEST_WORDS; k++) begin
            if (idx == idx_t'(k)) begin
                w = d[255 - 32*k -: 32];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/hash_digest_reader_if.sv
// Purpose: 32-bit digest word stream, valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: master holds out_word/out_last/out_valid until out_ready is seen.
// Signals: out_word, out_valid, out_last (master -> slave), out_ready (slave -> master).
interface hash_digest_reader_if;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    modport master (
        output out_word,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_word,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/hash_digest_reader_target_compare.sv
// Purpose: byte-reverse a SHA-256 digest into little-endian integer form and compare to target.
// Latency: combinational; the parent registers le.
// Backpressure: none.
// Ports: digest[255:0] (in), target[255:0] (in), le (out) = hash_le <= target.
module target_compare (
    input  logic [255:0] digest,
    input  logic [255:0] target,
    output logic         le
);

    logic [255:0] hash_le;

    // Byte 0 of the digest (bits [255:248]) becomes the least significant byte.
    for (genvar b = 0; b < 32; b++) begin : g_rev
        assign hash_le[8*b +: 8] = digest[255 - 8*b -: 8];
    end

    assign le = (hash_le <= target);

endmodule

// File: rtl/hash_digest_reader.sv
// Purpose: capture a finished digest, flag hash <= target, stream H0..H7 as 32-bit words.
// Latency: digest_done sampled at edge N+1 -> hit_valid/out_valid high after edge N+2.
// Backpressure: each word held until out_ready; digest_done while busy is dropped and sets sticky overrun.
// Ports: clk, rst (sync, active-high), digest_done, digest, target,
//        out_if (master: out_word/out_valid/out_last, out_ready), hit, hit_valid, busy, overrun.
module hash_digest_reader
    import hash_digest_reader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        digest_done,
    input  logic [255:0]                digest,
    input  logic [255:0]                target,
    hash_digest_reader_if.master        out_if,
    output logic                        hit,
    output logic                        hit_valid,
    output logic                        busy,
    output logic                        overrun
);

    state_t       state_q,     state_d;
    idx_t         idx_q,       idx_d;
    logic [255:0] digest_q,    digest_d;
    logic [255:0] target_q,    target_d;
    logic         hit_q,       hit_d;
    logic         hit_valid_q, hit_valid_d;
    logic         overrun_q,   overrun_d;
    logic         busy_q,      busy_d;
    logic         out_valid_q, out_valid_d;
    logic         out_last_q,  out_last_d;
    logic [31:0]  out_word_q,  out_word_d;
    logic         le;
    logic         xfer;

    target_compare u_target_compare (
        .digest (digest_q),
        .target (target_q),
        .le     (le)
    );

    assign xfer = out_valid_q && out_if.out_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        digest_d    = digest_q;
        target_d    = target_q;
        hit_d       = hit_q;
        hit_valid_d = hit_valid_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (digest_done) begin
                    digest_d    = digest;
                    target_d    = target;
                    hit_valid_d = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                hit_d       = le;
                hit_valid_d = 1'b1;
                idx_d       = '0;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer) begin
                    // Index parks at LAST_IDX on exit; CHECK rewinds it for the next stream.
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + idx_t'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (digest_done && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are registered from the next-state view so they line up with state_q.
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_STREAM);
        out_last_d  = (state_d == ST_STREAM) && (idx_d == LAST_IDX);
        out_word_d  = (state_d == ST_STREAM) ? word_at(digest_d, idx_d) : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            digest_q    <= '0;
            target_q    <= '0;
            hit_q       <= 1'b0;
            hit_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            digest_q    <= digest_d;
            target_q    <= target_d;
            hit_q       <= hit_d;
            hit_valid_q <= hit_valid_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_word_q  <= out_word_d;
        end
    end

    assign out_if.out_word  = out_word_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign hit              = hit_q;
    assign hit_valid        = hit_valid_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_hash_digest_reader.sv
// Purpose: self-checking bench for hash_digest_reader with a word/hit scoreboard.
// Latency: checks the two-edge digest_done -> valid latency directly.
// Backpressure: drives out_ready constant-high or pseudo-random and checks stall stability.
module tb_hash_digest_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         digest_done;
    logic [255:0] digest;
    logic [255:0] target;
    logic         hit, hit_valid, busy, overrun;

    hash_digest_reader_if u_if ();

    hash_digest_reader dut (
        .clk         (clk),
        .rst         (rst),
        .digest_done (digest_done),
        .digest      (digest),
        .target      (target),
        .out_if      (u_if),
        .hit         (hit),
        .hit_valid   (hit_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABC_LE = 256'had1500f2_61ff10b4_9c7a1796_a36103b0_2322ae5d_de404141_eacf018f_bf1678ba;
    localparam logic [255:0] ABC_LE_M1 = 256'had1500f2_61ff10b4_9c7a1796_a36103b0_2322ae5d_de404141_eacf018f_bf1678b9;
    localparam logic [255:0] ONES = {256{1'b1}};

    int n_chk  = 0;
    int n_fail = 0;
    int xfer_cnt = 0;

    logic [32:0] exp_w[$];   // {last, word}
    logic        exp_h[$];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;
    logic        prev_last  = 1'b0;
    logic        prev_hv    = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk1("stall_valid_held", u_if.out_valid, 1'b1);
                chkw("stall_word_held", u_if.out_word, prev_word);
                chk1("stall_last_held", u_if.out_last, prev_last);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                xfer_cnt++;
                if (exp_w.size() == 0) begin
                    chkw("unexpected_word", u_if.out_word, 32'hxxxxxxxx);
                end else begin
                    logic [32:0] e;
                    e = exp_w.pop_front();
                    chkw("out_word", u_if.out_word, e[31:0]);
                    chk1("out_last", u_if.out_last, e[32]);
                end
            end
            if (hit_valid && !prev_hv) begin
                if (exp_h.size() == 0) begin
                    chk1("unexpected_hit_valid", hit_valid, 1'b0);
                end else begin
                    chk1("hit", hit, exp_h.pop_front());
                end
            end
            prev_stall = u_if.out_valid && !u_if.out_ready;
            prev_word  = u_if.out_word;
            prev_last  = u_if.out_last;
        end
        prev_hv = hit_valid;
    end

    // Pulse digest_done and check the two-edge latency; leaves the bench at #1 after edge N+2.
    task automatic start(input logic [255:0] d, input logic [255:0] t, input logic eh);
        for (int k = 0; k < 8; k++) begin
            exp_w.push_back({(k == 7), d[255 - 32*k -: 32]});
        end
        exp_h.push_back(eh);
        digest      = d;
        target      = t;
        digest_done = 1'b1;
        @(posedge clk); #1;
        digest_done = 1'b0;
        chk1("lat1_busy", busy, 1'b1);
        chk1("lat1_hit_valid", hit_valid, 1'b0);
        chk1("lat1_out_valid", u_if.out_valid, 1'b0);
        @(posedge clk); #1;
        chk1("lat2_hit_valid", hit_valid, 1'b1);
        chk1("lat2_out_valid", u_if.out_valid, 1'b1);
        chkw("lat2_first_word", u_if.out_word, d[255:224]);
    endtask

    task automatic finish_stream(input int mode);
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            if (mode == 1) u_if.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        chk1("stream_done", busy, 1'b0);
        chk1("idle_out_valid", u_if.out_valid, 1'b0);
        u_if.out_ready = 1'b1;
    endtask

    task automatic run(input logic [255:0] d, input logic [255:0] t, input logic eh, input int mode);
        int base;
        base = xfer_cnt;
        u_if.out_ready = (mode == 1) ? 1'b0 : 1'b1;
        start(d, t, eh);
        finish_stream(mode);
        chkn("xfer_count", xfer_cnt - base, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst            = 1'b1;
        digest_done    = 1'b0;
        digest         = '0;
        target         = '0;
        u_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("rst_out_valid", u_if.out_valid, 1'b0);
        chk1("rst_out_last", u_if.out_last, 1'b0);
        chkw("rst_out_word", u_if.out_word, 32'd0);
        chk1("rst_hit", hit, 1'b0);
        chk1("rst_hit_valid", hit_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);

        // abc vectors, back-to-back with no idle gap between streams.
        run(ABC, ONES, 1'b1, 0);
        run(ABC, '0, 1'b0, 0);
        run(ABC, ABC_LE, 1'b1, 0);
        run(ABC, ABC_LE_M1, 1'b0, 0);

        // Random backpressure.
        run(ABC, ONES, 1'b1, 1);
        run(ABC, ABC_LE, 1'b1, 1);

        // digest_done while the third word is on the bus.
        base = xfer_cnt;
        u_if.out_ready = 1'b1;
        start(ABC, ONES, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("pre_overrun", overrun, 1'b0);
        chkw("third_word", u_if.out_word, 32'h414140de);
        digest      = ONES;
        target      = '0;
        digest_done = 1'b1;
        @(posedge clk); #1;
        digest_done = 1'b0;
        chk1("overrun_set", overrun, 1'b1);
        chk1("overrun_busy", busy, 1'b1);
        finish_stream(0);
        chkn("overrun_xfer_count", xfer_cnt - base, 8);
        chk1("hit_held", hit, 1'b1);
        chk1("hit_valid_held", hit_valid, 1'b1);
        chk1("overrun_sticky", overrun, 1'b1);

        // Reset while the fourth word is presented.
        start(ABC, '0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chkw("fourth_word", u_if.out_word, 32'h5dae2223);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_w.delete();
        chk1("mid_rst_out_valid", u_if.out_valid, 1'b0);
        chk1("mid_rst_out_last", u_if.out_last, 1'b0);
        chkw("mid_rst_out_word", u_if.out_word, 32'd0);
        chk1("mid_rst_hit", hit, 1'b0);
        chk1("mid_rst_hit_valid", hit_valid, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_overrun", overrun, 1'b0);
        @(posedge clk); #1;
        chk1("post_rst_no_valid", u_if.out_valid, 1'b0);
        run(ABC, ONES, 1'b1, 0);

        @(posedge clk); #1;
        chkn("words_left", exp_w.size(), 0);
        chkn("hits_left", exp_h.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
